// File: rtl/ldpc_3gpp_dec_mem_ctrl_pkg.sv
// Shared LDPC decoder types: lifting size, node strobes, read/write tag and
// the memory controller state encoding.
package ldpc_3gpp_dec_types;

  localparam int ZC_W    = 9;
  localparam int LAYER_W = 6;
  localparam int ITER_W  = 8;

  typedef logic [ZC_W-1:0]    hb_zc_t;
  typedef logic [LAYER_W-1:0] layer_t;
  typedef logic [ITER_W-1:0]  iter_t;

  typedef struct packed {
    logic sof;
    logic eof;
    logic sop;
    logic eop;
  } strb_t;

  typedef struct packed {
    logic   val;
    strb_t  strb;
    layer_t row;
  } tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Frame strobes are the layer strobes qualified by the first/last layer.
  function automatic strb_t make_strb(logic first_cyc, logic last_cyc,
                                      logic first_row, logic last_row);
    strb_t s;
    s.sof = first_cyc & first_row;
    s.eof = last_cyc & last_row;
    s.sop = first_cyc;
    s.eop = last_cyc;
    return s;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_mem_ctrl_if.sv
// Node-memory access tag bundle: valid, strobes and layer index.
interface ldpc_3gpp_dec_mem_ctrl_if;
  import ldpc_3gpp_dec_types::*;

  logic   val;
  strb_t  strb;
  layer_t row;

  modport master (output val, output strb, output row);
  modport slave  (input  val, input  strb, input  row);

endinterface

// File: rtl/ldpc_3gpp_dec_mem_ctrl_delay.sv
// Shift register aligning the read tag with the datapath write-back.
module ldpc_3gpp_dec_mem_ctrl_delay
  import ldpc_3gpp_dec_types::*;
#(
  parameter int pDELAY = 3
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  ldpc_3gpp_dec_mem_ctrl_if.slave    i_tag,
  ldpc_3gpp_dec_mem_ctrl_if.master   o_tag
);

  tag_t r_pipe [pDELAY];

  // NOTE: sequential state uses <= so every stage samples its neighbour's old value.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      // NOTE: every stage is cleared, otherwise a stale tag would surface as a write after reset.
      for (int i = 0; i < pDELAY; i++) r_pipe[i] <= '0;
    end else if (iclkena) begin
      r_pipe[0] <= {i_tag.val, i_tag.strb, i_tag.row};
      for (int i = 1; i < pDELAY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag.val  = r_pipe[pDELAY-1].val;
  assign o_tag.strb = r_pipe[pDELAY-1].strb;
  assign o_tag.row  = r_pipe[pDELAY-1].row;

endmodule

// File: rtl/ldpc_3gpp_dec_mem_ctrl.sv
// Layered LDPC node-memory controller: sweeps layers/iterations on the read
// side and replays the same tag stream on the write side after the pipe delay.
module ldpc_3gpp_dec_mem_ctrl
  import ldpc_3gpp_dec_types::*;
#(
  parameter int pADDR_W       = 8,
  parameter int pLLR_BY_CYCLE = 1,
  parameter int pPIPE_DELAY   = 3
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        iclkena,
  input  logic        istart,
  input  hb_zc_t      iused_zc,
  input  logic [5:0]  iused_row,
  input  logic [7:0]  iNiter,
  output logic        oread,
  output logic        orstart,
  output logic        orval,
  output strb_t       orstrb,
  output logic [5:0]  orow,
  output logic        owrite,
  output strb_t       owstrb,
  output logic [5:0]  owrow,
  output logic        obusy,
  output logic        odone,
  output logic [7:0]  oiter
);

  state_t               r_state;
  logic [pADDR_W-1:0]   r_len_m1;
  layer_t               r_rows_m1;
  iter_t                r_iters_m1;
  logic [pADDR_W-1:0]   r_cyc;
  layer_t               r_row;
  iter_t                r_iter;
  logic [3:0]           r_flush_cnt;
  logic                 r_read;
  logic                 r_rstart;
  strb_t                r_strb;
  logic                 r_busy;
  logic                 r_done;

  int                   w_len_int;
  logic [pADDR_W-1:0]   w_len_m1_in;
  layer_t               w_rows_m1_in;
  iter_t                w_iters_m1_in;
  strb_t                w_start_strb;

  logic                 w_last_cyc;
  logic                 w_last_row;
  logic                 w_last_iter;
  logic [pADDR_W-1:0]   w_nxt_cyc;
  layer_t               w_nxt_row;
  iter_t                w_nxt_iter;
  strb_t                w_nxt_strb;

  // Zero-sized layer, layer count or iteration count all collapse to one.
  always_comb begin
    w_len_int     = (int'(iused_zc) + pLLR_BY_CYCLE - 1) / pLLR_BY_CYCLE;
    w_len_m1_in   = (w_len_int == 0) ? '0 : pADDR_W'(w_len_int - 1);
    w_rows_m1_in  = (iused_row == '0) ? '0 : iused_row - 1'b1;
    w_iters_m1_in = (iNiter == '0) ? '0 : iNiter - 1'b1;
    w_start_strb  = make_strb(1'b1, w_len_m1_in == '0, 1'b1, w_rows_m1_in == '0);
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value unassigned (no latch).
    w_last_cyc  = (r_cyc == r_len_m1);
    w_last_row  = (r_row == r_rows_m1);
    w_last_iter = (r_iter == r_iters_m1);
    w_nxt_cyc   = r_cyc + 1'b1;
    w_nxt_row   = r_row;
    w_nxt_iter  = r_iter;
    if (w_last_cyc) begin
      w_nxt_cyc = '0;
      if (w_last_row) begin
        w_nxt_row  = '0;
        w_nxt_iter = r_iter + 1'b1;
      end else begin
        w_nxt_row = r_row + 1'b1;
      end
    end
    w_nxt_strb = make_strb(w_nxt_cyc == '0, w_nxt_cyc == r_len_m1,
                           w_nxt_row == '0, w_nxt_row == r_rows_m1);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state     <= ST_IDLE;
      r_len_m1    <= '0;
      r_rows_m1   <= '0;
      r_iters_m1  <= '0;
      r_cyc       <= '0;
      r_row       <= '0;
      r_iter      <= '0;
      r_flush_cnt <= '0;
      r_read      <= 1'b0;
      r_rstart    <= 1'b0;
      r_strb      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (iclkena) begin
      case (r_state)
        ST_IDLE: begin
          if (istart) begin
            r_len_m1   <= w_len_m1_in;
            r_rows_m1  <= w_rows_m1_in;
            r_iters_m1 <= w_iters_m1_in;
            r_cyc      <= '0;
            r_row      <= '0;
            r_iter     <= '0;
            r_read     <= 1'b1;
            r_rstart   <= 1'b1;
            r_strb     <= w_start_strb;
            r_busy     <= 1'b1;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_last_cyc && w_last_row && w_last_iter) begin
            r_read      <= 1'b0;
            r_rstart    <= 1'b0;
            r_strb      <= '0;
            r_row       <= '0;
            r_flush_cnt <= '0;
            r_state     <= ST_FLUSH;
          end else begin
            r_cyc    <= w_nxt_cyc;
            r_row    <= w_nxt_row;
            r_iter   <= w_nxt_iter;
            r_rstart <= (w_nxt_cyc == '0);
            r_strb   <= w_nxt_strb;
          end
        end
        // Wait for the last read to come out of the datapath as a write.
        ST_FLUSH: begin
          if (r_flush_cnt == 4'(pPIPE_DELAY - 1)) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ldpc_3gpp_dec_mem_ctrl_if u_rd_tag ();
  ldpc_3gpp_dec_mem_ctrl_if u_wr_tag ();

  assign u_rd_tag.val  = r_read;
  assign u_rd_tag.strb = r_strb;
  assign u_rd_tag.row  = r_row;

  ldpc_3gpp_dec_mem_ctrl_delay #(
    .pDELAY (pPIPE_DELAY)
  ) u_delay (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .i_tag   (u_rd_tag),
    .o_tag   (u_wr_tag)
  );

  assign oread   = r_read;
  assign orval   = r_read;
  assign orstart = r_rstart;
  assign orstrb  = r_strb;
  assign orow    = r_row;
  assign owrite  = u_wr_tag.val;
  assign owstrb  = u_wr_tag.strb;
  assign owrow   = u_wr_tag.row;
  assign obusy   = r_busy;
  assign odone   = r_done;
  assign oiter   = r_iter;

endmodule

// File: tb/tb_ldpc_3gpp_dec_mem_ctrl.sv
// Directed bench for the LDPC node-memory controller; all samples are taken
// on the falling edge, inputs are changed right after sampling.
module tb_ldpc_3gpp_dec_mem_ctrl;
  import ldpc_3gpp_dec_types::*;

  localparam int D = 3;

  logic        iclk = 1'b0;
  logic        ireset = 1'b1;
  logic        iclkena = 1'b1;
  logic        istart = 1'b0;
  hb_zc_t      iused_zc = '0;
  logic [5:0]  iused_row = '0;
  logic [7:0]  iNiter = '0;
  logic        oread, orstart, orval, owrite, obusy, odone;
  strb_t       orstrb, owstrb;
  logic [5:0]  orow, owrow;
  logic [7:0]  oiter;

  int n_checks = 0;
  int n_errors = 0;

  always #5 iclk = ~iclk;

  ldpc_3gpp_dec_mem_ctrl_if u_mon_if ();
  assign u_mon_if.val  = oread;
  assign u_mon_if.strb = orstrb;
  assign u_mon_if.row  = orow;

  ldpc_3gpp_dec_mem_ctrl #(
    .pADDR_W       (8),
    .pLLR_BY_CYCLE (1),
    .pPIPE_DELAY   (D)
  ) dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .iclkena   (iclkena),
    .istart    (istart),
    .iused_zc  (iused_zc),
    .iused_row (iused_row),
    .iNiter    (iNiter),
    .oread     (oread),
    .orstart   (orstart),
    .orval     (orval),
    .orstrb    (orstrb),
    .orow      (orow),
    .owrite    (owrite),
    .owstrb    (owstrb),
    .owrow     (owrow),
    .obusy     (obusy),
    .odone     (odone),
    .oiter     (oiter)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected tag for read-cycle k (1-based): {val, sof, eof, sop, eop, row[5:0]}.
  function automatic logic [10:0] exp_tag(int k, int len, int rows, int iters);
    int n, cyc, layer, row;
    logic [10:0] t;
    t = '0;
    n = k - 1;
    if (k < 1 || n >= len * rows * iters) return t;
    cyc   = n % len;
    layer = n / len;
    row   = layer % rows;
    t[10]  = 1'b1;
    t[9]   = (cyc == 0) && (row == 0);
    t[8]   = (cyc == len - 1) && (row == rows - 1);
    t[7]   = (cyc == 0);
    t[6]   = (cyc == len - 1);
    t[5:0] = row[5:0];
    return t;
  endfunction

  task automatic run_decode(input string name, input int zc, input int rows, input int iters,
                            input int freeze_at, input int freeze_len, input bit poke);
    int len, r, it, n, kmax, eff, dones;
    logic [10:0] t_rd, t_wr;
    len  = (zc == 0) ? 1 : zc;
    r    = (rows == 0) ? 1 : rows;
    it   = (iters == 0) ? 1 : iters;
    n    = len * r * it;
    kmax = n + D + freeze_len + 6;
    iused_zc  = hb_zc_t'(zc);
    iused_row = 6'(rows);
    iNiter    = 8'(iters);
    istart    = 1'b1;
    @(negedge iclk);
    istart    = 1'b0;
    // Scramble the configuration inputs; the running decode must ignore them.
    iused_zc  = iused_zc + 9'd5;
    iused_row = iused_row + 6'd3;
    iNiter    = iNiter + 8'd2;
    dones = 0;
    for (int k = 1; k <= kmax; k++) begin
      if (freeze_len > 0 && k > freeze_at + freeze_len) eff = k - freeze_len;
      else if (freeze_len > 0 && k > freeze_at)        eff = freeze_at;
      else                                             eff = k;
      t_rd = exp_tag(eff, len, r, it);
      t_wr = exp_tag(eff - D, len, r, it);
      check({name, "_rd"}, 64'({orstart, orval, u_mon_if.val, u_mon_if.strb, u_mon_if.row}),
            64'({t_rd[7], t_rd[10], t_rd}));
      check({name, "_wr"}, 64'({owrite, owstrb, owrow}), 64'(t_wr));
      check({name, "_stat"}, 64'({obusy, odone}),
            64'({(eff >= 1) && (eff <= n + D + 1), eff == n + D + 1}));
      if (t_rd[10]) check({name, "_iter"}, 64'(oiter), 64'((eff - 1) / len / r));
      if (odone) dones++;
      iclkena = !(freeze_len > 0 && k >= freeze_at && k < freeze_at + freeze_len);
      istart  = poke && (k == 2 || k == n + 2 || k == n + D + 1);
      @(negedge iclk);
    end
    istart  = 1'b0;
    iclkena = 1'b1;
    check({name, "_ndone"}, 64'(dones), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge iclk);
    check("rst_out", 64'({oread, orval, orstart, orstrb, orow, owrite, owstrb, owrow,
                          obusy, odone, oiter}), 64'd0);
    ireset = 1'b0;
    @(negedge iclk);

    // Zc=4, two layers, one iteration: hand-derived timeline relative to istart at T.
    iused_zc = 9'd4; iused_row = 6'd2; iNiter = 8'd1; istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      check("t1_oread",  64'(oread),  64'(k <= 8));
      check("t1_orstrb", 64'(orstrb), 64'({k == 1, k == 8, k == 1 || k == 5, k == 4 || k == 8}));
      check("t1_orow",   64'(orow),   64'(k >= 5 && k <= 8));
      check("t1_owrite", 64'(owrite), 64'(k >= 4 && k <= 11));
      check("t1_odone",  64'(odone),  64'(k == 12));
      check("t1_obusy",  64'(obusy),  64'(k <= 12));
      @(negedge iclk);
    end

    run_decode("zc2_i3", 2, 1, 3, 0, 0, 1'b0);
    run_decode("zc1",    1, 3, 2, 0, 0, 1'b0);
    run_decode("zero",   0, 0, 0, 0, 0, 1'b0);
    run_decode("frz",    4, 2, 1, 3, 5, 1'b0);

    // Reset on read cycle 3 with the clock enable low.
    iused_zc = 9'd4; iused_row = 6'd2; iNiter = 8'd1; istart = 1'b1;
    @(negedge iclk);
    istart = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("rr_oread", 64'(oread), 64'd1);
      @(negedge iclk);
    end
    ireset  = 1'b1;
    iclkena = 1'b0;
    @(negedge iclk);
    check("rr_zero", 64'({oread, orval, orstart, orstrb, orow, owrite, owstrb, owrow,
                          obusy, odone, oiter}), 64'd0);
    ireset  = 1'b0;
    iclkena = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge iclk);
      check("rr_quiet", 64'({oread, owrite, obusy, odone}), 64'd0);
    end

    run_decode("post_rst", 4, 2, 1, 0, 0, 1'b0);
    run_decode("poke",     3, 2, 1, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ldpc_3gpp_dec_mem_ctrl.md
LDPC_3GPP_DEC_MEM_CTRL -- requirements
Module: ldpc_3gpp_dec_mem_ctrl

Interface
REQ-001 SHALL have parameter pADDR_W, default 8: node memory address width; a layer holds at most 2**pADDR_W cycles.
REQ-002 SHALL have parameter pLLR_BY_CYCLE, default 1: LLRs processed per memory cycle.
REQ-003 SHALL have parameter pPIPE_DELAY, default 3, legal range 1..15: read-to-write-back latency of the decoder datapath, in cycles.
REQ-004 SHALL have port iclk, input, 1 bit: the single clock.
REQ-005 SHALL have port ireset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port iclkena, input, 1 bit: clock enable; when low, all state and outputs hold.
REQ-007 SHALL have port istart, input, 1 bit: start-of-decode pulse.
REQ-008 SHALL have port iused_zc, input, hb_zc_t: lifting size Zc.
REQ-009 SHALL have port iused_row, input, 6 bits: number of layers per iteration.
REQ-010 SHALL have port iNiter, input, 8 bits: number of iterations.
REQ-011 SHALL have port oread, input-side read enable to node memory, output, 1 bit.
REQ-012 SHALL have port orstart, output, 1 bit: first read cycle of each layer.
REQ-013 SHALL have port orval, output, 1 bit: read tag valid.
REQ-014 SHALL have port orstrb, output, strb_t: read strobes {sof, eof, sop, eop}.
REQ-015 SHALL have port orow, output, 6 bits: layer index being read.
REQ-016 SHALL have port owrite, output, 1 bit: write-back enable.
REQ-017 SHALL have port owstrb, output, strb_t: write-back strobes.
REQ-018 SHALL have port owrow, output, 6 bits: layer index being written.
REQ-019 SHALL have port obusy, output, 1 bit: controller is active.
REQ-020 SHALL have port odone, output, 1 bit: single-cycle completion pulse.
REQ-021 SHALL have port oiter, output, 8 bits: current iteration index.

Function
REQ-022 SHALL implement states IDLE, READ, FLUSH and DONE.
- IDLE->READ: on istart.
- READ->FLUSH: after the last cycle of the last layer of the last iteration.
- FLUSH->DONE: after pPIPE_DELAY cycles.
- DONE->IDLE: unconditionally.
REQ-023 SHALL sample iused_zc, iused_row and iNiter into registers at istart; later input changes SHALL have no effect on a running decode.
REQ-024 SHALL use layer length L = ceil(Zc/pLLR_BY_CYCLE) cycles; L=0 SHALL be treated as 1.
REQ-025 SHALL treat iused_row=0 and iNiter=0 as 1.
REQ-026 SHALL assert oread on the cycle after istart and hold it continuously for L*rows*iters cycles, with no gaps between layers or iterations.
REQ-027 SHALL drive orval identically to oread.
REQ-028 SHALL assert orstart on the first cycle of every layer.
REQ-029 SHALL set orstrb as follows:
- sop: first cycle of each layer.
- eop: last cycle of each layer.
- sof: first cycle of layer 0 of each iteration.
- eof: last cycle of the last layer of each iteration.
- When L=1, sop and eop SHALL both be asserted on the same cycle.
REQ-030 SHALL advance orow 0..rows-1 and wrap to 0 at the start of each iteration; oiter SHALL increment at each wrap.
REQ-031 SHALL produce owrite, owstrb and owrow as exact copies of oread, orstrb and orow delayed by pPIPE_DELAY enabled cycles.
REQ-032 SHALL assert obusy from the first oread cycle through the DONE cycle inclusive.
REQ-033 SHALL pulse odone in DONE, which is the cycle after the last owrite.
REQ-034 SHALL ignore istart whenever obusy is high.
REQ-035 SHALL treat istart arriving in the DONE cycle as ignored.

Reset
REQ-036 SHALL, on ireset, force all outputs to 0, the state to IDLE, and all counters and the delay line to 0, regardless of iclkena.
REQ-037 SHALL, on ireset during a decode, drop pending write-backs: no owrite SHALL occur after reset.

Structure
REQ-038 SHALL take strb_t and hb_zc_t from the shared ldpc_3gpp_dec_types package; the state enum and the layer and iteration widths SHALL live in the same package.
REQ-039 SHALL instantiate one sub-module, ldpc_3gpp_dec_mem_ctrl_delay: a parameterised shift register that carries {valid, strb, row} and clears on reset.

Verification
REQ-040 SHALL cover: Zc=4, pLLR=1, rows=2, iters=1, delay=3, istart at T -> oread T+1..T+8; sop at T+1 and T+5; eop at T+4 and T+8; sof at T+1; eof at T+8; owrite T+4..T+11; odone at T+12.
REQ-041 SHALL cover: Zc=2, rows=1, iters=3 -> 6 contiguous reads; sof/eof on every layer; oiter 0,0,1,1,2,2.
REQ-042 SHALL cover: Zc=1 -> sop and eop on the same cycle for every layer.
REQ-043 SHALL cover: iclkena low for 5 cycles mid-READ -> all outputs frozen, total read count unchanged, odone delayed by exactly 5 cycles.
REQ-044 SHALL cover: ireset at read cycle 3 -> all outputs 0 on the next cycle and no later owrite; a following istart runs a full, correct decode.
REQ-045 SHALL cover: istart pulses while obusy is high and in the DONE cycle -> ignored; odone occurs exactly once.
